// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: op codes, FSM states, default width.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [4:0] {
    ALU_AND  = 5'b00000,
    ALU_OR   = 5'b00001,
    ALU_XOR  = 5'b00010,
    ALU_ADD  = 5'b00011,
    ALU_SUB  = 5'b10011,
    ALU_SLL  = 5'b00110,
    ALU_SRL  = 5'b00111,
    ALU_SRA  = 5'b01000,
    ALU_SLT  = 5'b10100,
    ALU_SLTU = 5'b10101,
    ALU_MUL  = 5'b01001,
    ALU_MULH = 5'b01010
  } alucontrol_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_mul_op(input alucontrol_t op);
    return (op == ALU_MUL) || (op == ALU_MULH);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier retiring MUL_BPC multiplier bits per cycle.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned MUL_BPC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  output logic              done_c,
  output logic [2*XLEN-1:0] product
);

  localparam int unsigned ITERS = XLEN / MUL_BPC;
  localparam int unsigned CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] pp_c;

  // Partial product for the low MUL_BPC multiplier bits.
  always_comb begin
    pp_c = '0;
    for (int j = 0; j < int'(MUL_BPC); j++) begin
      if (mplier[j]) pp_c = pp_c + (mcand << j);
    end
  end

  assign done_c = run && (cnt == CW'(ITERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (start) begin
      mcand   <= (2*XLEN)'(opa);
      mplier  <= opb;
      product <= '0;
      cnt     <= '0;
    end else if (run) begin
      mcand   <= mcand << MUL_BPC;
      mplier  <= mplier >> MUL_BPC;
      product <= product + pp_c;
      cnt     <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshake and registered result/zero/illegal.
// ALU_DSP_MUL_EN: single-cycle DSP multiply instead of the iterative alu_mul_iter.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned MUL_BPC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  alucontrol_t     alucontrol,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  if (!((MUL_BPC == 1) || (MUL_BPC == 2) || (MUL_BPC == 4)) || ((XLEN % MUL_BPC) != 0)) begin : g_bad_cfg
    $error("alu_exec: MUL_BPC must be 1, 2 or 4 and divide XLEN");
  end

  state_t          state, state_nxt;
  logic            out_free_c;
  logic            accept_c;
  logic            is_mul_c;
  logic            mul_done_c;
  logic [XLEN-1:0] mul_res_c;
  logic [XLEN-1:0] alu_res_c;
  logic            alu_ill_c;
  logic            load_alu_c;
  logic            load_mul_c;

  assign out_free_c = !out_valid || out_ready;
  assign in_ready   = (state == IDLE) && out_free_c;
  assign accept_c   = in_valid && in_ready;
  assign busy       = (state == MUL);

`ifdef ALU_DSP_MUL_EN
  logic [2*XLEN-1:0] dsp_prod_c;

  assign dsp_prod_c = (2*XLEN)'($signed({{XLEN{srca[XLEN-1]}}, srca}) *
                                $signed({{XLEN{srcb[XLEN-1]}}, srcb}));
  assign is_mul_c   = 1'b0;
  assign mul_done_c = 1'b0;
  assign mul_res_c  = '0;
`else
  logic              mul_start_c;
  logic              mul_run_c;
  logic              mul_neg;
  logic              mul_hi;
  logic [XLEN-1:0]   abs_a_c;
  logic [XLEN-1:0]   abs_b_c;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] prod_s_c;

  assign is_mul_c    = is_mul_op(alucontrol);
  assign mul_start_c = accept_c && is_mul_c;
  assign mul_run_c   = (state == MUL);
  assign abs_a_c     = srca[XLEN-1] ? XLEN'(-srca) : srca;
  assign abs_b_c     = srcb[XLEN-1] ? XLEN'(-srcb) : srcb;

  // Sign and half selection captured at accept; applied in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_neg <= 1'b0;
      mul_hi  <= 1'b0;
    end else if (mul_start_c) begin
      mul_neg <= srca[XLEN-1] ^ srcb[XLEN-1];
      mul_hi  <= (alucontrol == ALU_MULH);
    end
  end

  assign prod_s_c  = mul_neg ? (2*XLEN)'(-product) : product;
  assign mul_res_c = mul_hi ? prod_s_c[2*XLEN-1:XLEN] : prod_s_c[XLEN-1:0];

  alu_mul_iter #(
    .XLEN    (XLEN),
    .MUL_BPC (MUL_BPC)
  ) u_mul_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_c),
    .run     (mul_run_c),
    .opa     (abs_a_c),
    .opb     (abs_b_c),
    .done_c  (mul_done_c),
    .product (product)
  );
`endif

  // Single-cycle datapath; mul codes land here only in the DSP build.
  always_comb begin
    alu_res_c = '0;
    alu_ill_c = 1'b0;
    case (alucontrol)
      ALU_AND:  alu_res_c = srca & srcb;
      ALU_OR:   alu_res_c = srca | srcb;
      ALU_XOR:  alu_res_c = srca ^ srcb;
      ALU_ADD:  alu_res_c = srca + srcb;
      ALU_SUB:  alu_res_c = srca - srcb;
      ALU_SLL:  alu_res_c = srca << srcb[SHW-1:0];
      ALU_SRL:  alu_res_c = srca >> srcb[SHW-1:0];
      ALU_SRA:  alu_res_c = XLEN'($signed(srca) >>> srcb[SHW-1:0]);
      ALU_SLT:  alu_res_c = XLEN'($signed(srca) < $signed(srcb));
      ALU_SLTU: alu_res_c = XLEN'(srca < srcb);
`ifdef ALU_DSP_MUL_EN
      ALU_MUL:  alu_res_c = dsp_prod_c[XLEN-1:0];
      ALU_MULH: alu_res_c = dsp_prod_c[2*XLEN-1:XLEN];
`else
      ALU_MUL, ALU_MULH: alu_res_c = '0;
`endif
      default:  alu_ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c && is_mul_c) state_nxt = MUL;
      MUL:     if (mul_done_c)           state_nxt = FIX;
      FIX:     if (out_free_c)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_alu_c = 1'b0;
    load_mul_c = 1'b0;
    case (state)
      IDLE:    load_alu_c = accept_c && !is_mul_c;
      FIX:     load_mul_c = out_free_c;
      default: ;
    endcase
  end

  // Output register: frozen while out_valid && !out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
    end else if (load_alu_c) begin
      out_valid <= 1'b1;
      result    <= alu_res_c;
      zero      <= (alu_res_c == '0);
      illegal   <= alu_ill_c;
    end else if (load_mul_c) begin
      out_valid <= 1'b1;
      result    <= mul_res_c;
      zero      <= (mul_res_c == '0);
      illegal   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, handshake sequences, random vs. model.
module tb_alu_exec;
  import alu_pkg::*;

`ifdef ALU_DSP_MUL_EN
  localparam int   MUL_LAT  = 1;
  localparam logic EXP_BUSY = 1'b0;
`else
  localparam int   MUL_LAT  = 34;
  localparam logic EXP_BUSY = 1'b1;
`endif
  localparam int N_RAND = 2000;
  localparam int N_VEC  = 19;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  alucontrol_t alucontrol;
  logic [31:0] srca, srcb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_exec dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=time limit reached required=self-termination");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zf;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs [N_VEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: {illegal, zero, result} from plain integer arithmetic.
  function automatic logic [33:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] pv;
    logic [31:0] r;
    logic        ill;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    p   = sa * sb;
    pv  = p;
    r   = '0;
    ill = 1'b0;
    case (op)
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b00010: r = a ^ b;
      5'b00011: r = a + b;
      5'b10011: r = a - b;
      5'b00110: r = a << b[4:0];
      5'b00111: r = a >> b[4:0];
      5'b01000: r = 32'($signed(a) >>> b[4:0]);
      5'b10100: r = (sa < sb) ? 32'd1 : 32'd0;
      5'b10101: r = (a < b) ? 32'd1 : 32'd0;
      5'b01001: r = pv[31:0];
      5'b01010: r = pv[63:32];
      default:  ill = 1'b1;
    endcase
    return {ill, (r == 32'd0), r};
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [4:0] rand_op();
    logic [4:0] codes [12];
    int         k;
    codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b10011, 5'b00110,
              5'b00111, 5'b01000, 5'b10100, 5'b10101, 5'b01001, 5'b01010};
    k = int'($urandom_range(0, 12));
    if (k == 12) return 5'($urandom_range(0, 31));
    return codes[k];
  endfunction

  task automatic run_vec(input int idx);
    int n;
    @(negedge clk);
    in_valid   = 1'b1;
    alucontrol = alucontrol_t'(vecs[idx].op);
    srca       = vecs[idx].a;
    srcb       = vecs[idx].b;
    out_ready  = 1'b1;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("vec%0d_latency", idx), 64'(n), 64'(vecs[idx].lat));
    chk($sformatf("vec%0d_out", idx), 64'({illegal, zero, result}),
        64'({vecs[idx].ill, vecs[idx].zf, vecs[idx].res}));
  endtask

  initial begin
    int          ghost;
    int          accepted;
    int          idle_cyc;
    bit          fire;
    logic [33:0] exp_q [$];
    logic [33:0] e;

    vecs[0]  = '{5'b00011, 32'd7,          32'hFFFF_FFFD, 32'd4,          1'b0, 1'b0, 1};
    vecs[1]  = '{5'b10011, 32'd5,          32'd5,         32'd0,          1'b1, 1'b0, 1};
    vecs[2]  = '{5'b01000, 32'h8000_0000,  32'd4,         32'hF800_0000,  1'b0, 1'b0, 1};
    vecs[3]  = '{5'b10101, 32'd1,          32'hFFFF_FFFF, 32'd1,          1'b0, 1'b0, 1};
    vecs[4]  = '{5'b10100, 32'd1,          32'hFFFF_FFFF, 32'd0,          1'b1, 1'b0, 1};
    vecs[5]  = '{5'b00000, 32'hF0F0_F0F0,  32'h0FF0_0FF0, 32'h00F0_00F0,  1'b0, 1'b0, 1};
    vecs[6]  = '{5'b00001, 32'h0000_0F00,  32'h0000_00F0, 32'h0000_0FF0,  1'b0, 1'b0, 1};
    vecs[7]  = '{5'b00010, 32'hFFFF_0000,  32'hFF00_FF00, 32'h00FF_FF00,  1'b0, 1'b0, 1};
    vecs[8]  = '{5'b00110, 32'd1,          32'h0000_003F, 32'h8000_0000,  1'b0, 1'b0, 1};
    vecs[9]  = '{5'b00111, 32'h8000_0000,  32'd31,        32'd1,          1'b0, 1'b0, 1};
    vecs[10] = '{5'b00011, 32'hFFFF_FFFF,  32'd1,         32'd0,          1'b1, 1'b0, 1};
    vecs[11] = '{5'b11111, 32'd5,          32'd6,         32'd0,          1'b1, 1'b1, 1};
    vecs[12] = '{5'b00011, 32'd2,          32'd3,         32'd5,          1'b0, 1'b0, 1};
    vecs[13] = '{5'b01001, 32'hFFFF_FFFF,  32'd3,         32'hFFFF_FFFD,  1'b0, 1'b0, MUL_LAT};
    vecs[14] = '{5'b01010, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000,  1'b0, 1'b0, MUL_LAT};
    vecs[15] = '{5'b01001, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000,  1'b1, 1'b0, MUL_LAT};
    vecs[16] = '{5'b01010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000,  1'b1, 1'b0, MUL_LAT};
    vecs[17] = '{5'b01010, 32'hFFFF_FFFF,  32'd3,         32'hFFFF_FFFF,  1'b0, 1'b0, MUL_LAT};
    vecs[18] = '{5'b01001, 32'd12345,      32'hFFFF_FFFE, 32'hFFFF_9F8E,  1'b0, 1'b0, MUL_LAT};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    alucontrol = ALU_ADD;
    srca       = '0;
    srcb       = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    64'(result),    64'd0);
    chk("rst_zero",      64'(zero),      64'd1);
    chk("rst_illegal",   64'(illegal),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a multiply.
    in_valid   = 1'b1;
    alucontrol = ALU_MUL;
    srca       = 32'd5;
    srcb       = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("midmul_busy", 64'(busy), 64'(EXP_BUSY));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy",      64'(busy),      64'd0);
    chk("midrst_zero",      64'(zero),      64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    ghost = 0;
    repeat (40) begin
      @(negedge clk);
      ghost += int'(out_valid);
    end
    chk("midrst_no_ghost_result", 64'(ghost), 64'd0);

    // Directed vector table.
    for (int i = 0; i < N_VEC; i++) run_vec(i);

    // Back-to-back issue, one op per cycle, results one cycle after accept.
    out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i - 1), 64'(out_valid), 64'd1);
        chk($sformatf("b2b%0d_out", i - 1), 64'({illegal, zero, result}),
            64'({vecs[i-1].ill, vecs[i-1].zf, vecs[i-1].res}));
      end
      if (i < 5) begin
        in_valid   = 1'b1;
        alucontrol = alucontrol_t'(vecs[i].op);
        srca       = vecs[i].a;
        srcb       = vecs[i].b;
        #1;
        chk($sformatf("b2b%0d_in_ready", i), 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: result held, no accept, queued op taken on release.
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    alucontrol = ALU_ADD;
    srca       = 32'd10;
    srcb       = 32'd20;
    @(negedge clk);
    chk("bp_first_valid", 64'(out_valid), 64'd1);
    alucontrol = ALU_XOR;
    srca       = 32'h0000_00FF;
    srcb       = 32'h0000_000F;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_in_ready_c%0d", i), 64'(in_ready), 64'd0);
      chk($sformatf("bp_hold_c%0d", i), 64'({out_valid, illegal, zero, result}),
          64'({1'b1, 1'b0, 1'b0, 32'd30}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_out", 64'({out_valid, illegal, zero, result}),
        64'({1'b1, 1'b0, 1'b0, 32'h0000_00F0}));
    @(negedge clk);

    // Random ops with random backpressure against the reference model.
    accepted = 0;
    idle_cyc = 0;
    fire     = 1'b0;
    while (accepted < N_RAND || exp_q.size() != 0) begin
      @(negedge clk);
      if (fire) in_valid = 1'b0;
      if (!in_valid && accepted < N_RAND && $urandom_range(0, 3) != 0) begin
        in_valid   = 1'b1;
        alucontrol = alucontrol_t'(rand_op());
        srca       = rand_opnd();
        srcb       = rand_opnd();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_op", 64'({illegal, zero, result}), 64'(e));
        end
        idle_cyc = 0;
      end
      fire = in_valid && in_ready;
      if (fire) begin
        exp_q.push_back(ref_model(alucontrol, srca, srcb));
        accepted++;
        idle_cyc = 0;
      end
      idle_cyc++;
      if (idle_cyc > 200) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout: actual=%0d pending results required=progress within 200 cycles", exp_q.size());
        break;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
